// File: rtl/ppu_reg_if.sv
// ppu_reg_if: CPU-facing PPU register responder ($2000-$3FFF, mirrored every 8 bytes).
// Holds PPUCTRL/PPUMASK/OAMADDR, the status flags, the loopy t/v/x/w scroll
// state and the $2007 read buffer, and drives NMI and VRAM/OAM/palette strobes.
// Optional feature macro: OPEN_BUS_DECAY_EN (open-bus latch decays to 0 after
// DECAY_CYCLES cycles without a refresh).
module ppu_reg_if #(
    parameter logic [23:0] DECAY_CYCLES = 24'd3_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    input  logic        vblank_set,
    input  logic        vblank_clr,
    input  logic        spr0_hit,
    input  logic        spr_ovf,
    output logic        nmi,
    output logic [7:0]  ctrl,
    output logic [7:0]  mask,
    output logic [14:0] t_addr,
    output logic [2:0]  fine_x,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    output logic        vram_wr,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic        pal_wr,
    input  logic [5:0]  pal_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_wr,
    input  logic [7:0]  oam_rdata
);

    // architectural state
    logic [7:0]  ctrl_q, mask_q, oam_q, buf_q, latch_q;
    logic [14:0] t_q, v_q;
    logic [2:0]  x_q;
    logic        w_q, vblank_q, spr0_q, ovf_q, pend_q;

    // next-state values
    logic [7:0]  ctrl_d, mask_d, oam_d, buf_d, latch_d;
    logic [14:0] t_d, v_d;
    logic [2:0]  x_d;
    logic        w_d, vblank_d, spr0_d, ovf_d, pend_d, nmi_d;

    logic        sel, wr_en, rd_en, rd7, is_pal;
    logic [2:0]  r;
    logic [14:0] inc;

    logic unused_addr;
    assign unused_addr = ^addr[12:3];

    assign sel    = (addr[15:13] == 3'b001);
    assign r      = addr[2:0];
    assign wr_en  = sel & ~rw;
    assign rd_en  = sel & rw;
    assign rd7    = rd_en & (r == 3'd7);
    assign is_pal = (v_q[13:8] == 6'h3F);
    assign inc    = ctrl_q[2] ? 15'd32 : 15'd1;

    assign ctrl     = ctrl_q;
    assign mask     = mask_q;
    assign t_addr   = t_q;
    assign fine_x   = x_q;
    assign oam_addr = oam_q;

    // bus read mux and memory-side strobes, all combinational on the current access
    always_comb begin
        data_o     = latch_q;
        vram_addr  = v_q[13:0];
        vram_rd    = 1'b0;
        vram_wr    = 1'b0;
        pal_wr     = 1'b0;
        oam_wr     = 1'b0;
        vram_wdata = data_i;
        if (rd_en) begin
            case (r)
                3'd2:    data_o = {vblank_q, spr0_q, ovf_q, latch_q[4:0]};
                3'd4:    data_o = oam_rdata;
                3'd7: begin
                    vram_rd = 1'b1;
                    if (is_pal) begin
                        // palette bypasses the buffer; buffer refills from the nametable underneath
                        data_o    = {latch_q[7:6], pal_rdata};
                        vram_addr = v_q[13:0] & 14'h2FFF;
                    end else begin
                        data_o = pend_q ? vram_rdata : buf_q;
                    end
                end
                default: data_o = latch_q;
            endcase
        end
        if (wr_en) begin
            if (r == 3'd4) oam_wr = 1'b1;
            if (r == 3'd7) begin
                pal_wr  = is_pal;
                vram_wr = ~is_pal;
            end
        end
    end

    // next-state for registers, scroll latches, flags, buffer and NMI
    always_comb begin
        ctrl_d   = ctrl_q;
        mask_d   = mask_q;
        oam_d    = oam_q;
        t_d      = t_q;
        v_d      = v_q;
        x_d      = x_q;
        w_d      = w_q;
        vblank_d = vblank_q;
        spr0_d   = spr0_q;
        ovf_d    = ovf_q;
        // a pending fetch always lands in the buffer; a new $2007 read re-arms it
        buf_d    = pend_q ? vram_rdata : buf_q;
        pend_d   = rd7;
        latch_d  = latch_q;

        if (wr_en) begin
            latch_d = data_i;
            case (r)
                3'd0: begin
                    ctrl_d     = data_i;
                    t_d[11:10] = data_i[1:0];
                end
                3'd1: mask_d = data_i;
                3'd3: oam_d  = data_i;
                3'd4: oam_d  = oam_q + 8'd1;
                3'd5: begin
                    if (!w_q) begin
                        t_d[4:0] = data_i[7:3];
                        x_d      = data_i[2:0];
                        w_d      = 1'b1;
                    end else begin
                        t_d[14:12] = data_i[2:0];
                        t_d[9:5]   = data_i[7:3];
                        w_d        = 1'b0;
                    end
                end
                3'd6: begin
                    if (!w_q) begin
                        t_d[13:8] = data_i[5:0];
                        t_d[14]   = 1'b0;
                        w_d       = 1'b1;
                    end else begin
                        t_d[7:0] = data_i;
                        v_d      = {t_q[14:8], data_i};
                        w_d      = 1'b0;
                    end
                end
                3'd7: v_d = v_q + inc;
                default: ;
            endcase
        end

        if (rd_en) begin
            latch_d = data_o;
            if (r == 3'd7) v_d = v_q + inc;
        end

        // flag pulses; a $2002 read wins over a coincident vblank_set
        if (vblank_set) vblank_d = 1'b1;
        if (spr0_hit)   spr0_d   = 1'b1;
        if (spr_ovf)    ovf_d    = 1'b1;
        if (vblank_clr) begin
            vblank_d = 1'b0;
            spr0_d   = 1'b0;
            ovf_d    = 1'b0;
        end
        if (rd_en && r == 3'd2) begin
            vblank_d = 1'b0;
            w_d      = 1'b0;
        end

        // NMI follows the values being registered so it reacts one cycle after the cause
        nmi_d = ctrl_d[7] & vblank_d;
    end

`ifdef OPEN_BUS_DECAY_EN
    logic [23:0] decay_cnt;
    logic        decay_hit;
    assign decay_hit = (decay_cnt == DECAY_CYCLES - 24'd1);

    // idle counter for the open-bus latch; any selected access refreshes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      decay_cnt <= '0;
        else if (sel)                    decay_cnt <= '0;
        else if (decay_cnt != DECAY_CYCLES) decay_cnt <= decay_cnt + 24'd1;
    end

    // open-bus latch with decay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         latch_q <= '0;
        else if (sel)       latch_q <= latch_d;
        else if (decay_hit) latch_q <= '0;
    end
`else
    logic [23:0] unused_decay;
    assign unused_decay = DECAY_CYCLES;

    // open-bus latch holds until the next selected access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) latch_q <= '0;
        else        latch_q <= latch_d;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            mask_q   <= '0;
            oam_q    <= '0;
            t_q      <= '0;
            v_q      <= '0;
            x_q      <= '0;
            w_q      <= 1'b0;
            vblank_q <= 1'b0;
            spr0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            buf_q    <= '0;
            pend_q   <= 1'b0;
            nmi      <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            mask_q   <= mask_d;
            oam_q    <= oam_d;
            t_q      <= t_d;
            v_q      <= v_d;
            x_q      <= x_d;
            w_q      <= w_d;
            vblank_q <= vblank_d;
            spr0_q   <= spr0_d;
            ovf_q    <= ovf_d;
            buf_q    <= buf_d;
            pend_q   <= pend_d;
            nmi      <= nmi_d;
        end
    end

endmodule

// File: doc/ppu_reg_if.md
Name: ppu_reg_if

Overview:
- CPU-facing register responder of the PPU. It decodes CPU bus accesses to $2000-$3FFF, mirrored every 8 bytes.
- It holds PPUCTRL, PPUMASK, OAMADDR, the status flags, the scroll/address latches (t, v, x, w) and the $2007 read buffer.
- It drives NMI and issues VRAM/OAM/palette accesses.
- It sits between the CPU bus (or the CPU stimulus model) and the PPU renderer/memories.

Parameters:
- DECAY_CYCLES, 24'd3_000_000, clk cycles without refresh before open-bus bits decay to 0 (only used when OPEN_BUS_DECAY_EN is defined).

Ports:
- clk  in  1  CPU-rate clock; one bus access per cycle.
- rst_n  in  1  asynchronous active-low reset.
- rw  in  1  1=read, 0=write.
- addr  in  16  CPU address; selected when addr[15:13]==3'b001; register = addr[2:0].
- data_i  in  8  CPU write data.
- data_o  out  8  CPU read data; combinational from addr and current state, valid in the same cycle.
- vblank_set  in  1  pulse from timing at start of vblank.
- vblank_clr  in  1  pulse at pre-render line.
- spr0_hit, spr_ovf  in  1  set pulses from the renderer.
- nmi  out  1  registered, active-high NMI request.
- ctrl, mask  out  8  PPUCTRL and PPUMASK register contents.
- t_addr  out  15  loopy t; fine_x  out  3  fine X scroll.
- vram_addr  out  14; vram_rd, vram_wr  out  1; vram_wdata  out  8; vram_rdata  in  8, valid the cycle after vram_rd.
- pal_wr  out  1; pal_rdata  in  6, combinational from vram_addr[4:0].
- oam_addr  out  8; oam_wr  out  1; oam_rdata  in  8, combinational.

Behaviour:
- Reset (async, rst_n=0): all registers 0 (ctrl, mask, t, v, x, w, oam_addr, status flags, read buffer, open-bus latch, rd_pending). Outputs at reset: nmi=0, all strobes 0.
- Open-bus latch: every selected write loads data_i; every selected read loads data_o.
- Reads of write-only registers ($2000,$2001,$2003,$2005,$2006) return the latch. Writing $2000=0x90 then reading $2000 returns 0x90.
- $2000 write: ctrl<=d; t[11:10]<=d[1:0].
- $2001 write: mask<=d.
- $2002 read: data_o={vblank, spr0, ovf, latch[4:0]}. At the clock edge it clears vblank and w.
- $2003 write: oam_addr<=d.
- $2004 write: oam_wr=1 (same cycle, combinational), then oam_addr+1 (8-bit wrap). $2004 read returns oam_rdata with no increment.
- $2005 write, w=0: t[4:0]<=d[7:3], x<=d[2:0], w<=1.
- $2005 write, w=1: t[14:12]<=d[2:0], t[9:5]<=d[7:3], w<=0.
- $2006 write, w=0: t[13:8]<=d[5:0], t[14]<=0, w<=1.
- $2006 write, w=1: t[7:0]<=d, v<=new t, w<=0.
- Common to $2006 w=1 and $2007: inc = ctrl[2] ? 32 : 1; v<=v+inc, 15-bit wrap; vram_addr=v[13:0] combinationally.
- $2007 write, v[13:8]==6'h3F: pal_wr=1. Otherwise vram_wr=1, vram_wdata=d. Either way v+=inc.
- $2007 read, v<3F00: data_o=buffer (if rd_pending, data_o=vram_rdata). vram_rd=1, rd_pending<=1, v+=inc.
- $2007 read, v>=3F00: data_o={latch[7:6], pal_rdata}. vram_rd=1 with vram_addr=v[13:0]&14'h2FFF to refill the buffer, v+=inc.
- When rd_pending: buffer<=vram_rdata and rd_pending<=0, unless a new $2007 read re-arms it. Back-to-back $2007 reads return consecutive bytes after the first dummy.
- Status flags: vblank_set sets vblank; vblank_clr clears vblank, spr0 and ovf; spr0_hit / spr_ovf set their flags.
- $2002 read coinciding with vblank_set: read returns vblank=0, the flag stays 0 and no NMI occurs that frame.
- nmi<=ctrl[7]&vblank, registered. Setting ctrl[7] while vblank=1 raises nmi next cycle. Clearing ctrl[7] or vblank drops nmi next cycle.
- Unselected cycles (e.g. addr=0): no state change except flag pulses and buffer fill.

Optional Feature:
- OPEN_BUS_DECAY_EN defined: a per-latch counter is reset on any latch load. After DECAY_CYCLES idle cycles the latch clears to 0x00.
- OPEN_BUS_DECAY_EN undefined: the latch holds indefinitely and there is no counter.

Test Plan:
- Write $2000=0x90, read $2000 -> data_o=0x90 same cycle; ctrl=0x90; t[11:10]=0.
- ctrl=0x90, pulse vblank_set -> nmi=1 next cycle. Read $2002 -> data_o[7]=1; the cycle after, nmi=0, vblank=0, w=0.
- Writes $2005=0x7D, $2005=0x5E -> t_addr=15'h616F, fine_x=5, w=0. Read $2002 between two writes resets w.
- Writes $2006=0x21, 0x08, then $2007 0xAA, 0xBB with ctrl[2]=0 -> vram_wr at 0x2108/0x2109. Repeat with ctrl[2]=1 -> 0x2108/0x2128.
- v=0x2000, memory 0x11,0x22: consecutive $2007 reads -> stale buffer, 0x11, 0x22. v=0x3F01 -> pal_rdata returned directly, vram_rd at 0x2F01.
- Assert rst_n=0 mid-$2006 sequence (w=1) -> nmi=0, w=0, t=0 immediately; the next $2006 write is treated as the first write.
